reg_bus_master: RTL and testbench

- Host-side initiator for the MAC's 16-bit CPU register bus (CSB/WRB/CA/CD_in/CD_out).
- Accepts single read/write requests on a valid/ready handshake and generates the bus cycle with programmable setup/strobe/hold timing.
- Returns read data or an error on a response handshake.
- Lets an embedded controller or test sequencer program and poll MAC registers (watermarks, IFG, speed, RMON access) without hand-built bus timing.

---
 rtl/mac_reg_pkg.sv | 79 +++++++
 rtl/reg_bus_master.sv | 156 +++++++++++++++
 tb/tb_reg_bus_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_reg_pkg.sv
// Shared definitions for the MAC CPU register bus: FSM states, register map,
// data widths and register reset defaults.
package mac_reg_pkg;

    localparam int REG_IDX_W  = 7;
    localparam int REG_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Register indices; the bus byte address is {index, 1'b0}.
    localparam logic [REG_IDX_W-1:0] REG_TX_HWMARK            = 7'd0;
    localparam logic [REG_IDX_W-1:0] REG_TX_LWMARK            = 7'd1;
    localparam logic [REG_IDX_W-1:0] REG_PAUSE_FRAME_SEND_EN  = 7'd2;
    localparam logic [REG_IDX_W-1:0] REG_PAUSE_QUANTA_SET     = 7'd3;
    localparam logic [REG_IDX_W-1:0] REG_IFG_SET              = 7'd4;
    localparam logic [REG_IDX_W-1:0] REG_FULL_DUPLEX          = 7'd5;
    localparam logic [REG_IDX_W-1:0] REG_MAX_RETRY            = 7'd6;
    localparam logic [REG_IDX_W-1:0] REG_TX_ADD_EN            = 7'd7;
    localparam logic [REG_IDX_W-1:0] REG_TX_ADD_PROM_DATA     = 7'd8;
    localparam logic [REG_IDX_W-1:0] REG_TX_ADD_PROM_ADD      = 7'd9;
    localparam logic [REG_IDX_W-1:0] REG_TX_ADD_PROM_WR       = 7'd10;
    localparam logic [REG_IDX_W-1:0] REG_TX_PAUSE_EN          = 7'd11;
    localparam logic [REG_IDX_W-1:0] REG_XOFF_CPU             = 7'd12;
    localparam logic [REG_IDX_W-1:0] REG_XON_CPU              = 7'd13;
    localparam logic [REG_IDX_W-1:0] REG_RX_ADD_CHK_EN        = 7'd14;
    localparam logic [REG_IDX_W-1:0] REG_RX_ADD_PROM_DATA     = 7'd15;
    localparam logic [REG_IDX_W-1:0] REG_RX_ADD_PROM_ADD      = 7'd16;
    localparam logic [REG_IDX_W-1:0] REG_RX_ADD_PROM_WR       = 7'd17;
    localparam logic [REG_IDX_W-1:0] REG_BROADCAST_FILTER_EN  = 7'd18;
    localparam logic [REG_IDX_W-1:0] REG_BROADCAST_BUCKET_DEP = 7'd19;
    localparam logic [REG_IDX_W-1:0] REG_BROADCAST_BUCKET_INT = 7'd20;
    localparam logic [REG_IDX_W-1:0] REG_RX_APPEND_CRC        = 7'd21;
    localparam logic [REG_IDX_W-1:0] REG_RX_HWMARK            = 7'd22;
    localparam logic [REG_IDX_W-1:0] REG_RX_LWMARK            = 7'd23;
    localparam logic [REG_IDX_W-1:0] REG_CRC_CHK_EN           = 7'd24;
    localparam logic [REG_IDX_W-1:0] REG_RX_IFG_SET           = 7'd25;
    localparam logic [REG_IDX_W-1:0] REG_RX_MAX_LENGTH        = 7'd26;
    localparam logic [REG_IDX_W-1:0] REG_CPU_RD_GRANT         = 7'd30;
    localparam logic [REG_IDX_W-1:0] REG_CPU_RD_DOUT          = 7'd31;
    localparam logic [REG_IDX_W-1:0] REG_SPEED                = 7'd33;

    localparam logic [REG_DATA_W-1:0] DEF_TX_HWMARK     = 16'h001E;
    localparam logic [REG_DATA_W-1:0] DEF_TX_LWMARK     = 16'h0019;
    localparam logic [REG_DATA_W-1:0] DEF_PAUSE_QUANTA  = 16'h00FF;
    localparam logic [REG_DATA_W-1:0] DEF_IFG_SET       = 16'h001E;
    localparam logic [REG_DATA_W-1:0] DEF_FULL_DUPLEX   = 16'h0001;
    localparam logic [REG_DATA_W-1:0] DEF_MAX_RETRY     = 16'h0002;
    localparam logic [REG_DATA_W-1:0] DEF_RX_HWMARK     = 16'h0018;
    localparam logic [REG_DATA_W-1:0] DEF_RX_LWMARK     = 16'h0010;
    localparam logic [REG_DATA_W-1:0] DEF_CRC_CHK_EN    = 16'h0001;
    localparam logic [REG_DATA_W-1:0] DEF_RX_IFG_SET    = 16'h000C;
    localparam logic [REG_DATA_W-1:0] DEF_RX_MAX_LENGTH = 16'h2710;
    localparam logic [REG_DATA_W-1:0] DEF_SPEED         = 16'h0004;

    function automatic logic [REG_DATA_W-1:0] reg_default(input logic [REG_IDX_W-1:0] idx);
        case (idx)
            REG_TX_HWMARK:        return DEF_TX_HWMARK;
            REG_TX_LWMARK:        return DEF_TX_LWMARK;
            REG_PAUSE_QUANTA_SET: return DEF_PAUSE_QUANTA;
            REG_IFG_SET:          return DEF_IFG_SET;
            REG_FULL_DUPLEX:      return DEF_FULL_DUPLEX;
            REG_MAX_RETRY:        return DEF_MAX_RETRY;
            REG_RX_HWMARK:        return DEF_RX_HWMARK;
            REG_RX_LWMARK:        return DEF_RX_LWMARK;
            REG_CRC_CHK_EN:       return DEF_CRC_CHK_EN;
            REG_RX_IFG_SET:       return DEF_RX_IFG_SET;
            REG_RX_MAX_LENGTH:    return DEF_RX_MAX_LENGTH;
            REG_SPEED:            return DEF_SPEED;
            default:              return '0;
        endcase
    endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Single-request initiator for the MAC CPU register bus with programmable
// setup/strobe/hold timing and a valid/ready request/response interface.
module reg_bus_master
    import mac_reg_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned MAX_IDX    = 33
) (
    input  logic                  Clk_reg,
    input  logic                  Reset_n,
    input  logic                  Req_valid,
    output logic                  Req_ready,
    input  logic                  Req_wr,
    input  logic [REG_IDX_W-1:0]  Req_idx,
    input  logic [REG_DATA_W-1:0] Req_wdata,
    output logic                  Rsp_valid,
    input  logic                  Rsp_ready,
    output logic [REG_DATA_W-1:0] Rsp_rdata,
    output logic                  Rsp_err,
    output logic                  Busy,
    output logic                  CSB,
    output logic                  WRB,
    output logic [7:0]            CA,
    output logic [REG_DATA_W-1:0] CD_in,
    input  logic [REG_DATA_W-1:0] CD_out
);

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);
    localparam bit         HAS_HOLD    = (HOLD_CYC != 0);
    localparam logic [REG_IDX_W-1:0] MAX_IDX_L = REG_IDX_W'(MAX_IDX);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [7:0]            ca_q, ca_d;
    logic [REG_DATA_W-1:0] cd_q, cd_d;
    logic [REG_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  csb_q, csb_d;
    logic                  wrb_q, wrb_d;

    always_comb begin
        // NOTE: every signal takes its held value first so no branch can leave
        // one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ca_d    = ca_q;
        cd_d    = cd_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (Req_valid) begin
                    wr_d    = Req_wr;
                    rdata_d = '0;
                    if (Req_idx > MAX_IDX_L) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        ca_d    = {Req_idx, 1'b0};
                        if (Req_wr) begin
                            cd_d = Req_wdata;
                        end
                        cnt_d   = SETUP_LOAD;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    // Writes always strobe for a single cycle.
                    cnt_d   = wr_q ? 4'd0 : STROBE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rdata_d = CD_out;
                    end
                    if (HAS_HOLD) begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (Rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight from flops.
        csb_d = (state_d != ST_STROBE);
        wrb_d = !((state_d == ST_STROBE) && wr_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            ca_q    <= 8'd0;
            cd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            csb_q   <= 1'b1;
            wrb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ca_q    <= ca_d;
            cd_q    <= cd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            csb_q   <= csb_d;
            wrb_q   <= wrb_d;
        end
    end

    assign Req_ready = (state_q == ST_IDLE);
    assign Rsp_valid = (state_q == ST_RESP);
    assign Busy      = (state_q != ST_IDLE);
    assign Rsp_rdata = rdata_q;
    assign Rsp_err   = err_q;
    assign CSB       = csb_q;
    assign WRB       = wrb_q;
    assign CA        = ca_q;
    assign CD_in     = cd_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: a register-file slave on the bus,
// a table of directed vectors, multi-cycle corner sequences and random traffic.
module tb_reg_bus_master;
    import mac_reg_pkg::*;

    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int MAX_IDX    = 33;
    localparam int LAT_W      = 1 + SETUP_CYC + 1 + HOLD_CYC;
    localparam int LAT_R      = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC;
    localparam int TIMEOUT    = 64;
    localparam logic [6:0] MAXI = 7'd33;

    logic        Clk_reg = 1'b0;
    logic        Reset_n;
    logic        Req_valid, Req_ready, Req_wr;
    logic [6:0]  Req_idx;
    logic [15:0] Req_wdata;
    logic        Rsp_valid, Rsp_ready, Rsp_err, Busy;
    logic [15:0] Rsp_rdata;
    logic        CSB, WRB;
    logic [7:0]  CA;
    logic [15:0] CD_in, CD_out;

    reg_bus_master #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .MAX_IDX   (MAX_IDX)
    ) dut (
        .Clk_reg  (Clk_reg),
        .Reset_n  (Reset_n),
        .Req_valid(Req_valid),
        .Req_ready(Req_ready),
        .Req_wr   (Req_wr),
        .Req_idx  (Req_idx),
        .Req_wdata(Req_wdata),
        .Rsp_valid(Rsp_valid),
        .Rsp_ready(Rsp_ready),
        .Rsp_rdata(Rsp_rdata),
        .Rsp_err  (Rsp_err),
        .Busy     (Busy),
        .CSB      (CSB),
        .WRB      (WRB),
        .CA       (CA),
        .CD_in    (CD_in),
        .CD_out   (CD_out)
    );

    always #5 Clk_reg = ~Clk_reg;

    int checks = 0;
    int errors = 0;

    // Slave register file with its own reset so a master reset does not disturb it.
    logic        slv_rst_n;
    logic [15:0] slv_mem [0:33];
    logic        ovr_en;
    logic [15:0] ovr_val;

    always @(posedge Clk_reg or negedge slv_rst_n) begin
        if (!slv_rst_n) begin
            for (int i = 0; i <= 33; i++) slv_mem[i] <= reg_default(7'(i));
        end else if (!CSB && !WRB && CA[7:1] <= MAXI) begin
            slv_mem[CA[7:1]] <= CD_in;
        end
    end

    assign CD_out = ovr_en ? ovr_val : ((CA[7:1] <= MAXI) ? slv_mem[CA[7:1]] : 16'h0000);

    // Bus-level monitors: completed write strobes and the WRB-implies-CSB rule.
    int wrb_edges = 0;
    int inv_bad   = 0;
    always @(posedge Clk_reg) begin
        if (Reset_n === 1'b1 && WRB === 1'b0) wrb_edges <= wrb_edges + 1;
    end
    always @(negedge Clk_reg) begin
        if (Reset_n === 1'b1 && WRB === 1'b0 && CSB !== 1'b0) inv_bad <= inv_bad + 1;
    end

    // Reference model: register contents and number of writes expected on the bus.
    logic [15:0] ref_mem [0:33];
    int          exp_writes = 0;

    typedef struct {
        logic        wr;
        logic [6:0]  idx;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl [10];

    logic        tr_csb [0:15];
    logic        tr_wrb [0:15];
    logic [7:0]  tr_ca  [0:15];
    logic [15:0] tr_cd  [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a falling edge with the master idle; returns on the falling
    // edge after the response handshake.
    task automatic do_txn(input logic wr, input logic [6:0] idx, input logic [15:0] wdata,
                          input int rsp_delay, input logic early_rdy,
                          input int chg_cycle, input logic [15:0] chg_val,
                          output logic [15:0] rdata, output logic err, output int lat,
                          output int csb_lo, output int wrb_lo);
        int ca_bad = 0;
        int cd_bad = 0;
        check("req_ready_idle", Req_ready, 1);
        Req_valid = 1'b1;
        Req_wr    = wr;
        Req_idx   = idx;
        Req_wdata = wdata;
        @(posedge Clk_reg);
        @(negedge Clk_reg);
        Req_valid = 1'b0;
        Req_wr    = 1'($urandom);
        Req_idx   = 7'($urandom);
        Req_wdata = 16'($urandom);
        if (early_rdy) Rsp_ready = 1'b1;
        lat = 0; csb_lo = 0; wrb_lo = 0;
        rdata = '0; err = 1'b0;
        for (int n = 1; n <= TIMEOUT; n++) begin
            if (n == chg_cycle) ovr_val = chg_val;
            if (Rsp_valid) begin
                lat = n;
                break;
            end
            if (n < 16) begin
                tr_csb[n] = CSB; tr_wrb[n] = WRB; tr_ca[n] = CA; tr_cd[n] = CD_in;
            end
            if (!CSB) csb_lo++;
            if (!WRB) wrb_lo++;
            if (CA !== {idx, 1'b0}) ca_bad++;
            if (wr && CD_in !== wdata) cd_bad++;
            @(negedge Clk_reg);
        end
        if (lat == 0) begin
            check("rsp_timeout", 0, 1);
            Rsp_ready = 1'b0;
            return;
        end
        if (idx <= MAXI) begin
            check("ca_stable", ca_bad, 0);
            check("cd_stable", cd_bad, 0);
        end
        rdata = Rsp_rdata;
        err   = Rsp_err;
        for (int k = 0; k < rsp_delay; k++) begin
            @(negedge Clk_reg);
            check("hold_valid", Rsp_valid, 1);
            check("hold_rdata", Rsp_rdata, rdata);
            check("hold_err", Rsp_err, err);
            check("hold_req_ready", Req_ready, 0);
            check("hold_csb", CSB, 1);
        end
        Rsp_ready = 1'b1;
        @(posedge Clk_reg);
        @(negedge Clk_reg);
        Rsp_ready = 1'b0;
        check("rsp_dropped", Rsp_valid, 0);
        check("ready_back", Req_ready, 1);
    endtask

    task automatic run_vec(input string name, input vec_t v, input int rsp_delay,
                           input logic early_rdy, input int chg_cycle, input logic [15:0] chg_val);
        logic [15:0] rdata;
        logic        err;
        int          lat, csb_lo, wrb_lo;
        do_txn(v.wr, v.idx, v.wdata, rsp_delay, early_rdy, chg_cycle, chg_val,
               rdata, err, lat, csb_lo, wrb_lo);
        check({name, "_rdata"}, rdata, v.exp_rdata);
        check({name, "_err"}, err, v.exp_err);
        check({name, "_lat"}, lat, v.exp_lat);
        check({name, "_csb_cycles"}, csb_lo, v.exp_err ? 0 : (v.wr ? 1 : STROBE_CYC));
        check({name, "_wrb_cycles"}, wrb_lo, (!v.exp_err && v.wr) ? 1 : 0);
        if (v.wr && !v.exp_err) begin
            exp_writes++;
            ref_mem[v.idx] = v.wdata;
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [6:0] idx, input logic [15:0] wdata,
                                input logic [15:0] rdata, input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.idx = idx; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        logic        wr, err;
        logic [6:0]  idx;
        logic [15:0] wdata, rdata;
        logic        early;
        int          dly;

        for (int i = 0; i <= 33; i++) ref_mem[i] = reg_default(7'(i));

        tbl[0] = mk(1'b1, 7'd22,  16'h5A5A, 16'h0000, 1'b0, LAT_W);
        tbl[1] = mk(1'b0, 7'd26,  16'h0000, 16'h2710, 1'b0, LAT_R);
        tbl[2] = mk(1'b0, 7'd40,  16'h0000, 16'h0000, 1'b1, 1);
        tbl[3] = mk(1'b0, 7'd22,  16'h0000, 16'h5A5A, 1'b0, LAT_R);
        tbl[4] = mk(1'b1, 7'd34,  16'hBEEF, 16'h0000, 1'b1, 1);
        tbl[5] = mk(1'b1, 7'd33,  16'h0002, 16'h0000, 1'b0, LAT_W);
        tbl[6] = mk(1'b0, 7'd33,  16'h0000, 16'h0002, 1'b0, LAT_R);
        tbl[7] = mk(1'b0, 7'd127, 16'h0000, 16'h0000, 1'b1, 1);
        tbl[8] = mk(1'b0, 7'd0,   16'h0000, 16'h001E, 1'b0, LAT_R);
        tbl[9] = mk(1'b0, 7'd1,   16'h0000, 16'h0033, 1'b0, LAT_R);

        Reset_n   = 1'b0;
        slv_rst_n = 1'b0;
        Req_valid = 1'b0; Req_wr = 1'b0; Req_idx = '0; Req_wdata = '0;
        Rsp_ready = 1'b0;
        ovr_en    = 1'b0; ovr_val = '0;
        #12;
        check("rst_csb", CSB, 1);
        check("rst_wrb", WRB, 1);
        check("rst_ca", CA, 0);
        check("rst_cd_in", CD_in, 0);
        check("rst_req_ready", Req_ready, 1);
        check("rst_rsp_valid", Rsp_valid, 0);
        check("rst_rdata", Rsp_rdata, 0);
        check("rst_err", Rsp_err, 0);
        check("rst_busy", Busy, 0);
        @(negedge Clk_reg);
        Reset_n   = 1'b1;
        slv_rst_n = 1'b1;
        @(negedge Clk_reg);

        // Write idx 22: address/data in cycles 1-3, strobe only in cycle 2.
        run_vec("wr22", mk(1'b1, 7'd22, 16'h001A, 16'h0000, 1'b0, LAT_W), 0, 1'b0, 0, '0);
        for (int n = 1; n <= 3; n++) begin
            check($sformatf("wr22_ca_c%0d", n), tr_ca[n], 8'h2C);
            check($sformatf("wr22_cd_c%0d", n), tr_cd[n], 16'h001A);
            check($sformatf("wr22_csb_c%0d", n), tr_csb[n], (n != 2) ? 1 : 0);
            check($sformatf("wr22_wrb_c%0d", n), tr_wrb[n], (n != 2) ? 1 : 0);
        end
        check("wr22_slave", slv_mem[22], 16'h001A);

        // Read idx 26: strobe in cycles 2-3, WRB never low.
        run_vec("rd26", mk(1'b0, 7'd26, 16'h0000, DEF_RX_MAX_LENGTH, 1'b0, LAT_R), 0, 1'b0, 0, '0);
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("rd26_csb_c%0d", n), tr_csb[n], (n == 2 || n == 3) ? 0 : 1);
            check($sformatf("rd26_wrb_c%0d", n), tr_wrb[n], 1);
        end

        // Response back-pressure for 10 cycles, then a back-to-back write.
        run_vec("rd33_hold", mk(1'b0, 7'd33, 16'h0000, 16'h0004, 1'b0, LAT_R), 10, 1'b0, 0, '0);
        run_vec("b2b_wr1", mk(1'b1, 7'd1, 16'h0033, 16'h0000, 1'b0, LAT_W), 0, 1'b0, 0, '0);

        // Reset during the write strobe of idx 4.
        Req_valid = 1'b1; Req_wr = 1'b1; Req_idx = 7'd4; Req_wdata = 16'h0010;
        @(posedge Clk_reg);
        @(negedge Clk_reg);
        Req_valid = 1'b0;
        @(negedge Clk_reg);
        check("rst_mid_pre_csb", CSB, 0);
        check("rst_mid_pre_wrb", WRB, 0);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_mid_csb", CSB, 1);
        check("rst_mid_wrb", WRB, 1);
        @(negedge Clk_reg);
        Reset_n = 1'b1;
        @(negedge Clk_reg);
        check("rst_mid_req_ready", Req_ready, 1);
        check("rst_mid_rsp_valid", Rsp_valid, 0);
        check("rst_mid_ifgset", slv_mem[4], DEF_IFG_SET);

        // CD_out changes after the read sample edge; the earlier value is kept.
        ovr_en  = 1'b1;
        ovr_val = 16'h1111;
        run_vec("rd_late_change", mk(1'b0, 7'd5, 16'h0000, 16'h1111, 1'b0, LAT_R), 0, 1'b0,
                1 + SETUP_CYC + STROBE_CYC, 16'h2222);
        ovr_en = 1'b0;

        // Rsp_ready held high before Rsp_valid must not shorten the transaction.
        run_vec("early_rdy_rd", mk(1'b0, 7'd22, 16'h0000, 16'h001A, 1'b0, LAT_R), 0, 1'b1, 0, '0);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i], i % 3, 1'b0, 0, '0);
        end

        for (int i = 0; i < 150; i++) begin
            wr    = 1'($urandom_range(0, 1));
            idx   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(34, 127)) : 7'($urandom_range(0, 33));
            wdata = 16'($urandom);
            err   = (idx > MAXI);
            rdata = (err || wr) ? 16'h0000 : ref_mem[idx];
            early = ($urandom_range(0, 3) == 0);
            dly   = early ? 0 : $urandom_range(0, 3);
            run_vec($sformatf("rnd%0d", i), mk(wr, idx, wdata, rdata, err,
                    err ? 1 : (wr ? LAT_W : LAT_R)), dly, early, 0, '0);
        end

        for (int i = 0; i <= 33; i++) begin
            check($sformatf("final_reg%0d", i), slv_mem[i], ref_mem[i]);
        end
        check("write_strobe_count", wrb_edges, exp_writes);
        check("wrb_implies_csb", inv_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
